// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel, redirect input,
// and the instruction handshake toward operand fetch. master = fetch unit, slave = environment.
interface fetch_prefetch_unit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            imem_req_valid_out;
    logic            imem_req_ready_in;
    logic [XLEN-1:0] imem_addr_out;
    logic            imem_rsp_valid_in;
    logic [XLEN-1:0] imem_rsp_data_in;
    logic            isbranchTaken_in;
    logic [XLEN-1:0] branchPC_in;
    logic            inst_valid_out;
    logic            inst_ready_in;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] inst_pc_out;
    logic [CW-1:0]   occupancy_out;

    modport master (
        output imem_req_valid_out, imem_addr_out, inst_valid_out, inst_out, inst_pc_out, occupancy_out,
        input  imem_req_ready_in, imem_rsp_valid_in, imem_rsp_data_in, isbranchTaken_in, branchPC_in,
               inst_ready_in
    );

    modport slave (
        input  imem_req_valid_out, imem_addr_out, inst_valid_out, inst_out, inst_pc_out, occupancy_out,
        output imem_req_ready_in, imem_rsp_valid_in, imem_rsp_data_in, isbranchTaken_in, branchPC_in,
               inst_ready_in
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Prefetching fetch stage: issues pipelined in-order memory requests and queues PC-tagged
// instructions. Optional FETCH_PERF_CNT_EN adds saturating pop/redirect counters.
module fetch_prefetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] PC_RESET   = {XLEN{1'b0}},
    parameter int              INST_BYTES = 4
) (
    input  logic clk_in,
    input  logic rst_in,
`ifdef FETCH_PERF_CNT_EN
    fetch_prefetch_unit_if.master bus_if,
    output logic [31:0] perf_fetched_out,
    output logic [31:0] perf_flush_out
`else
    fetch_prefetch_unit_if.master bus_if
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);
    localparam logic [XLEN-1:0] PC_INC  = XLEN'(INST_BYTES);

    logic [XLEN-1:0] q_inst_q [DEPTH];
    logic [XLEN-1:0] q_pc_q   [DEPTH];
    logic [XLEN-1:0] pcf_q    [DEPTH];

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   pcf_rd_q, pcf_rd_d, pcf_wr_q, pcf_wr_d;
    logic [CW-1:0]   occ_q, occ_d, outst_q, outst_d, disc_q, disc_d;
    logic            req_en_q;

    logic [CW+1:0]   credit_sum_s;
    logic            req_valid_s, accept_s, head_valid_s, pop_s;
    logic            drop_s, take_s, rsp_hit_s;

    // Queue entries plus everything still owed by memory must fit in the queue.
    assign credit_sum_s = {2'b00, occ_q} + {2'b00, outst_q} + {2'b00, disc_q};
    assign req_valid_s  = req_en_q && !bus_if.isbranchTaken_in && (credit_sum_s < (CW+2)'(DEPTH));
    assign accept_s     = req_valid_s && bus_if.imem_req_ready_in;
    assign head_valid_s = (occ_q != {CW{1'b0}});
    assign pop_s        = head_valid_s && bus_if.inst_ready_in;
    assign drop_s       = bus_if.imem_rsp_valid_in && (disc_q != {CW{1'b0}});
    assign take_s       = bus_if.imem_rsp_valid_in && (disc_q == {CW{1'b0}}) &&
                          (outst_q != {CW{1'b0}}) && !bus_if.isbranchTaken_in;
    assign rsp_hit_s    = bus_if.imem_rsp_valid_in &&
                          ((disc_q != {CW{1'b0}}) || (outst_q != {CW{1'b0}}));

    assign bus_if.imem_req_valid_out = req_valid_s;
    assign bus_if.imem_addr_out      = pc_q;
    assign bus_if.inst_valid_out     = head_valid_s;
    assign bus_if.inst_out           = head_valid_s ? q_inst_q[rd_ptr_q] : {XLEN{1'b0}};
    assign bus_if.inst_pc_out        = head_valid_s ? q_pc_q[rd_ptr_q]   : {XLEN{1'b0}};
    assign bus_if.occupancy_out      = occ_q;

    // Next-state for PC, queue/PC-FIFO pointers and in-flight bookkeeping; redirect wins.
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        pcf_rd_d = pcf_rd_q;
        pcf_wr_d = pcf_wr_q;
        occ_d    = occ_q;
        outst_d  = outst_q;
        disc_d   = disc_q;
        if (bus_if.isbranchTaken_in) begin
            // Every in-flight request becomes a discard; a response this cycle retires one of them.
            pc_d     = bus_if.branchPC_in;
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            pcf_rd_d = {PW{1'b0}};
            pcf_wr_d = {PW{1'b0}};
            occ_d    = {CW{1'b0}};
            outst_d  = {CW{1'b0}};
            disc_d   = disc_q + outst_q - CW'(rsp_hit_s);
        end else begin
            if (accept_s) begin
                pc_d     = pc_q + PC_INC;
                pcf_wr_d = pcf_wr_q + PTR_ONE;
            end else begin
                pc_d     = pc_q;
                pcf_wr_d = pcf_wr_q;
            end
            if (take_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                pcf_rd_d = pcf_rd_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
                pcf_rd_d = pcf_rd_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            outst_d = outst_q + CW'(accept_s) - CW'(take_s);
            disc_d  = disc_q - CW'(drop_s);
            occ_d   = occ_q + CW'(take_s) - CW'(pop_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q     <= PC_RESET;
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            pcf_rd_q <= {PW{1'b0}};
            pcf_wr_q <= {PW{1'b0}};
            occ_q    <= {CW{1'b0}};
            outst_q  <= {CW{1'b0}};
            disc_q   <= {CW{1'b0}};
            req_en_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            pcf_rd_q <= pcf_rd_d;
            pcf_wr_q <= pcf_wr_d;
            occ_q    <= occ_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
            req_en_q <= 1'b1;
        end
    end

    // Storage arrays; contents are only observed through valid pointers, so no reset.
    always_ff @(posedge clk_in) begin
        if (take_s) begin
            q_inst_q[wr_ptr_q] <= bus_if.imem_rsp_data_in;
            q_pc_q[wr_ptr_q]   <= pcf_q[pcf_rd_q];
        end
        if (accept_s) begin
            pcf_q[pcf_wr_q] <= pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_flush_q;

    // Saturating counters of dequeue handshakes and redirect cycles.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_fetched_q <= 32'd0;
            perf_flush_q   <= 32'd0;
        end else begin
            if (pop_s && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (bus_if.isbranchTaken_in && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_fetched_out = perf_fetched_q;
    assign perf_flush_out   = perf_flush_q;
`endif
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit: a latency-programmable memory model feeds responses,
// accepted requests push expected {inst, pc} entries, dequeues pop and compare.
module tb_fetch_prefetch_unit;
    typedef struct {logic [31:0] data; int due;} rsp_t;
    typedef struct {logic [31:0] inst; logic [31:0] pc;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pops_cnt = 0;
    int   flush_cnt = 0;
    int   lat = 1;
    logic mem_ready = 1'b0;
    logic cons_ready = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    rsp_t mem_q[$];
    exp_t exp_q[$];

    fetch_prefetch_unit_if #(.XLEN(32), .DEPTH(4)) bus_if ();
    fetch_prefetch_unit_if #(.XLEN(32), .DEPTH(4)) w_if ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flush, w_perf_fetched, w_perf_flush;
    fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .PC_RESET(32'h0), .INST_BYTES(4)) dut (
        .clk_in(clk), .rst_in(rst), .bus_if(bus_if),
        .perf_fetched_out(perf_fetched), .perf_flush_out(perf_flush));
    fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .PC_RESET(32'hFFFF_FFFC), .INST_BYTES(4)) dut_wrap (
        .clk_in(clk), .rst_in(rst), .bus_if(w_if),
        .perf_fetched_out(w_perf_fetched), .perf_flush_out(w_perf_flush));
`else
    fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .PC_RESET(32'h0), .INST_BYTES(4)) dut (
        .clk_in(clk), .rst_in(rst), .bus_if(bus_if));
    fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .PC_RESET(32'hFFFF_FFFC), .INST_BYTES(4)) dut_wrap (
        .clk_in(clk), .rst_in(rst), .bus_if(w_if));
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic br, input logic [31:0] tgt);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus_if.imem_rsp_valid_in = 1'b1;
            bus_if.imem_rsp_data_in  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            bus_if.imem_rsp_valid_in = 1'b0;
            bus_if.imem_rsp_data_in  = 32'h0;
        end
        bus_if.imem_req_ready_in = mem_ready;
        bus_if.inst_ready_in     = cons_ready;
        bus_if.isbranchTaken_in  = br;
        bus_if.branchPC_in       = tgt;
    endtask

    task automatic observe(input logic br, input logic [31:0] tgt);
        exp_t e;
        if (bus_if.inst_valid_out && bus_if.inst_ready_in) begin
            pops_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("pop_unexpected_pc", bus_if.inst_pc_out, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check_eq("inst", bus_if.inst_out, e.inst);
                check_eq("inst_pc", bus_if.inst_pc_out, e.pc);
            end
        end
        if (bus_if.imem_req_valid_out && bus_if.imem_req_ready_in) begin
            check_eq("req_addr", bus_if.imem_addr_out, exp_pc);
            mem_q.push_back('{mem_word(exp_pc), cyc + lat});
            exp_q.push_back('{mem_word(exp_pc), exp_pc});
            exp_pc = exp_pc + 32'd4;
        end
        if (br) begin
            check_eq("redir_noreq", 32'(bus_if.imem_req_valid_out), 32'd0);
            exp_q.delete();
            exp_pc = tgt;
            flush_cnt++;
        end
    endtask

    task automatic step(input logic br, input logic [31:0] tgt);
        drive(br, tgt);
        #1;
        observe(br, tgt);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, 32'(bus_if.imem_req_valid_out), 32'd0);
        check_eq({tag, "_inst_valid"}, 32'(bus_if.inst_valid_out), 32'd0);
        check_eq({tag, "_inst"}, bus_if.inst_out, 32'd0);
        check_eq({tag, "_inst_pc"}, bus_if.inst_pc_out, 32'd0);
        check_eq({tag, "_occ"}, 32'(bus_if.occupancy_out), 32'd0);
    endtask

    initial begin
        bit found;
        w_if.imem_req_ready_in = 1'b1;
        w_if.imem_rsp_valid_in = 1'b0;
        w_if.imem_rsp_data_in  = 32'h0;
        w_if.isbranchTaken_in  = 1'b0;
        w_if.branchPC_in       = 32'h0;
        w_if.inst_ready_in     = 1'b0;
        drive(1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Backpressure from reset: consumer stalled, memory latency 1.
        mem_ready = 1'b1; cons_ready = 1'b0; lat = 1; exp_pc = 32'h0;
        step(1'b0, 32'h0);
        drive(1'b0, 32'h0); #1;
        check_eq("first_req_valid", 32'(bus_if.imem_req_valid_out), 32'd1);
        check_eq("first_req_addr", bus_if.imem_addr_out, 32'h0);
        check_eq("wrap_addr0", w_if.imem_addr_out, 32'hFFFF_FFFC);
        observe(1'b0, 32'h0); @(negedge clk);
        drive(1'b0, 32'h0); #1;
        check_eq("wrap_addr1", w_if.imem_addr_out, 32'h0);
        observe(1'b0, 32'h0); @(negedge clk);
        repeat (7) step(1'b0, 32'h0);
        cons_ready = 1'b1;
        drive(1'b0, 32'h0); #1;
        check_eq("bp_occ_full", 32'(bus_if.occupancy_out), 32'd4);
        check_eq("bp_req_blocked", 32'(bus_if.imem_req_valid_out), 32'd0);
        check_eq("bp_head_pc", bus_if.inst_pc_out, 32'h0);
        observe(1'b0, 32'h0); @(negedge clk);
        cons_ready = 1'b0;
        drive(1'b0, 32'h0); #1;
        check_eq("bp_reenable_valid", 32'(bus_if.imem_req_valid_out), 32'd1);
        check_eq("bp_reenable_addr", bus_if.imem_addr_out, 32'd16);
        observe(1'b0, 32'h0); @(negedge clk);
        drive(1'b0, 32'h0); #1;
        check_eq("bp_only_one", 32'(bus_if.imem_req_valid_out), 32'd0);
        observe(1'b0, 32'h0); @(negedge clk);

        // Sequential streaming.
        cons_ready = 1'b1;
        repeat (16) step(1'b0, 32'h0);

        // Redirect with requests in flight at latency 3.
        lat = 3;
        repeat (10) step(1'b0, 32'h0);
        step(1'b1, 32'h100);
        drive(1'b0, 32'h0); #1;
        check_eq("redir_occ", 32'(bus_if.occupancy_out), 32'd0);
        observe(1'b0, 32'h0); @(negedge clk);
        repeat (14) step(1'b0, 32'h0);

        // Redirect landing on a cycle with both a response and a pop.
        lat = 1;
        repeat (6) step(1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc && bus_if.inst_valid_out) begin
                found = 1'b1;
                step(1'b1, 32'h200);
            end else begin
                step(1'b0, 32'h0);
            end
        end
        check_eq("coincide_found", 32'(found), 32'd1);
        drive(1'b0, 32'h0); #1;
        check_eq("coincide_occ", 32'(bus_if.occupancy_out), 32'd0);
        check_eq("coincide_req_valid", 32'(bus_if.imem_req_valid_out), 32'd1);
        check_eq("coincide_req_addr", bus_if.imem_addr_out, 32'h200);
        observe(1'b0, 32'h0); @(negedge clk);
        repeat (10) step(1'b0, 32'h0);

        // Reset mid-stream with three requests outstanding.
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() == 3) found = 1'b1;
            else step(1'b0, 32'h0);
        end
        check_eq("mid_rst_three_outstanding", 32'(found), 32'd1);
        rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        exp_q.delete(); exp_pc = 32'h0; mem_ready = 1'b0; pops_cnt = 0; flush_cnt = 0;
        @(negedge clk);
        step(1'b0, 32'h0);
        rst = 1'b0;
        step(1'b0, 32'h0);
        for (int i = 0; i < 10 && mem_q.size() > 0; i++) step(1'b0, 32'h0);
        check_eq("late_rsp_drained", 32'(mem_q.size()), 32'd0);
        drive(1'b0, 32'h0); #1;
        check_eq("post_rst_req_valid", 32'(bus_if.imem_req_valid_out), 32'd1);
        check_eq("post_rst_req_addr", bus_if.imem_addr_out, 32'h0);
        check_eq("post_rst_occ", 32'(bus_if.occupancy_out), 32'd0);
        observe(1'b0, 32'h0); @(negedge clk);
        mem_ready = 1'b1; lat = 1;
        repeat (12) step(1'b0, 32'h0);
        step(1'b1, 32'h300);
        repeat (8) step(1'b0, 32'h0);

        // Drain everything still owed.
        mem_ready = 1'b0;
        for (int i = 0; i < 30 && (mem_q.size() > 0 || exp_q.size() > 0); i++) step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        check_eq("drain_expected_empty", 32'(exp_q.size()), 32'd0);
        check_eq("drain_occ", 32'(bus_if.occupancy_out), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetched", perf_fetched, 32'(pops_cnt));
        check_eq("perf_flush", perf_flush, 32'(flush_cnt));
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised successor to the single-cycle fetch stage.
- Owns the PC and issues pipelined requests to instruction memory using a valid/ready request channel and an in-order response channel.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry prefetch queue.
- Presents them to operand fetch through a valid/ready handshake; a taken branch flushes the queue and discards stale in-flight responses.

Parameters:
- XLEN, 32, instruction and address width in bits.
- DEPTH, 4, prefetch queue entries; power of 2, >= 2.
- PC_RESET, 0, PC loaded on reset.
- INST_BYTES, 4, PC increment per sequential fetch.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- imem_req_valid_out  output  1  fetch request valid.
- imem_req_ready_in  input  1  memory accepts the request this cycle.
- imem_addr_out  output  XLEN  fetch address, equal to the current fetch PC.
- imem_rsp_valid_in  input  1  response data valid; responses return in request order.
- imem_rsp_data_in  input  XLEN  returned instruction word.
- isbranchTaken_in  input  1  redirect strobe from the branch unit.
- branchPC_in  input  XLEN  redirect target.
- inst_valid_out  output  1  queue head valid.
- inst_ready_in  input  1  operand fetch consumes the head this cycle.
- inst_out  output  XLEN  head instruction.
- inst_pc_out  output  XLEN  PC of the head instruction.
- occupancy_out  output  $clog2(DEPTH)+1  number of valid queue entries.

Behaviour:
- Reset (asynchronous assert, takes effect immediately):
  - fetch PC = PC_RESET; queue empty; outstanding = 0; discard = 0.
  - imem_req_valid_out = 0; inst_valid_out = 0; inst_out = 0; inst_pc_out = 0; occupancy_out = 0.
- First request: imem_req_valid_out rises in the first clock cycle after rst_in deasserts, with imem_addr_out = PC_RESET.
- Request acceptance: a request is accepted when imem_req_valid_out && imem_req_ready_in. On acceptance, fetch PC += INST_BYTES (wraps modulo 2^XLEN) and outstanding += 1.
- Credit rule: imem_req_valid_out = !isbranchTaken_in && (occupancy + outstanding + discard) < DEPTH. The queue can never overflow.
- Address stability: imem_addr_out stays stable while a request is valid but not accepted.
- Responses:
  - If discard > 0: the response is dropped and discard -= 1.
  - Otherwise: {imem_rsp_data_in, PC of the oldest outstanding request} is written at the queue tail, and outstanding -= 1.
  - The oldest outstanding PC comes from an internal DEPTH-entry PC FIFO, pushed on each request acceptance.
- Response latency: any response latency >= 1 cycle is legal. A written entry is visible on inst_out one cycle after imem_rsp_valid_in (registered; no bypass).
- Stray response: imem_rsp_valid_in with outstanding == 0 and discard == 0 is ignored.
- Dequeue: head pops when inst_valid_out && inst_ready_in. inst_out and inst_pc_out hold while valid && !ready.
- Simultaneous write and pop: allowed. Occupancy is unchanged; wrap-around of read/write pointers is modulo DEPTH.
- Redirect (isbranchTaken_in = 1), highest priority:
  - Queue flushes; occupancy_out = 0 next cycle.
  - discard += outstanding; outstanding = 0 (both including any acceptance/response occurring that cycle). A response arriving in the redirect cycle is dropped.
  - fetch PC = branchPC_in.
  - No request is issued in the redirect cycle. The first request to branchPC_in is issued the following cycle, subject to the credit rule.
  - A pop in the redirect cycle completes as a handshake but has no further effect.
- Back-to-back redirects: the last one wins.
- Alignment: branchPC_in low bits are not checked; the address is issued as given.
- Reset mid-operation: all in-flight state is cleared. Responses arriving after reset are treated as stray (see Stray response).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two outputs, both reset to 0 and saturating at all-ones:
  - perf_fetched_out (32b): count of dequeue handshakes.
  - perf_flush_out (32b): count of redirect cycles.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Sequential streaming (DEPTH=4, PC_RESET=0, ready always high, response latency 1, inst_ready_in=1): requests issue at addresses 0, 4, 8, 12. inst_pc_out sequence is 0, 4, 8, 12, and inst_out matches memory contents.
- Backpressure (inst_ready_in=0): after 4 responses, occupancy_out=4 and imem_req_valid_out=0. Raising inst_ready_in for one cycle pops PC 0 and re-enables exactly one request, at address 16.
- Redirect with in-flight requests (latency 3, 2 outstanding, branchPC_in=0x100): queue empties; the next 2 responses are dropped. The first inst_pc_out after the redirect is 0x100, then 0x104.
- Redirect coinciding with a response and a pop: no stale instruction appears; occupancy_out=0 the next cycle; the next request goes to branchPC_in.
- Reset asserted mid-stream with 3 outstanding: all outputs go to 0 immediately. After release, the first request is to PC_RESET, and late responses are ignored.
- PC wrap (PC_RESET=0xFFFFFFFC): second fetch address is 0x00000000. With FETCH_PERF_CNT_EN defined, perf_fetched_out counts pops, and perf_flush_out increments once per redirect.
